jtag_cmd_sequencer: RTL

Upstream command front-end for the jtag shifter block. Accepts a byte-stream of host commands over a valid/ready port. Splits each command into an instruction word or a 4-word data burst and buffers it in two internal first-word-fall-through (FWFT) FIFOs. Drives op/work to the shifter and tracks its busy handshake, launching one transaction at a time.

---
 rtl/jtag_cmd_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_cmd_sequencer.sv
// Host command front-end for the jtag shifter: parses header/payload bytes into two FWFT FIFOs
// and launches one shifter transaction at a time. Optional busy watchdog: JTAG_SEQ_TIMEOUT_EN.
module jtag_cmd_sequencer #(
    parameter int DATA_INSTRUCTION = 6,
    parameter int DATA_FIFO        = 8,
    parameter int FIFO_DEPTH       = 16,
    parameter int DATA_WORDS       = 4,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [7:0]                  cmd_data,
    output logic                        op,
    output logic                        work,
    input  logic                        busy,
    output logic [DATA_INSTRUCTION-1:0] rdata_instruction,
    input  logic                        rd_instruction,
    output logic                        empty_instruction,
    output logic [DATA_FIFO-1:0]        rdata_data,
    input  logic                        rd_data,
    output logic                        empty_data,
    output logic                        done,
    output logic                        err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WORDS) + 1;

    if (FIFO_DEPTH < DATA_WORDS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("jtag_cmd_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {S_HDR, S_PAYLOAD, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} state_e;

    state_e        state_q, state_d;
    logic          op_q, op_d, work_q, work_d, done_q, done_d, err_q, err_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   iw_ptr_q, iw_ptr_d, ir_ptr_q, ir_ptr_d;
    logic [AW:0]   dw_ptr_q, dw_ptr_d, dr_ptr_q, dr_ptr_d;
    logic          xfer, push_instr, push_data, pop_instr, pop_data, flush;

    logic [DATA_INSTRUCTION-1:0] imem [FIFO_DEPTH];
    logic [DATA_FIFO-1:0]        dmem [FIFO_DEPTH];

`ifdef JTAG_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    // Pointers carry one extra wrap bit so equal indices distinguish full from empty.
    function automatic logic ptr_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    assign xfer              = cmd_valid && cmd_ready_q;
    assign empty_instruction = (iw_ptr_q == ir_ptr_q);
    assign empty_data        = (dw_ptr_q == dr_ptr_q);
    assign pop_instr         = rd_instruction && !empty_instruction;
    assign pop_data          = rd_data && !empty_data;
    assign rdata_instruction = empty_instruction ? '0 : imem[ir_ptr_q[AW-1:0]];
    assign rdata_data        = empty_data ? '0 : dmem[dr_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        work_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        push_instr = 1'b0;
        push_data  = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_HDR: if (xfer) begin
                if (cmd_data[6]) begin
                    err_d = 1'b1;
                end else if (cmd_data[7]) begin
                    op_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PAYLOAD;
                end else begin
                    op_d       = 1'b0;
                    push_instr = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_PAYLOAD: if (xfer) begin
                push_data = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WORDS - 1)) state_d = S_LAUNCH;
            end
            S_LAUNCH: if (!busy) begin
                work_d  = 1'b1;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: if (busy) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!busy) begin
                done_d  = 1'b1;
                state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase

`ifdef JTAG_SEQ_TIMEOUT_EN
        to_cnt_d = '0;
        if (state_q == S_WAIT_HI || state_q == S_WAIT_LO) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                flush   = 1'b1;
                err_d   = 1'b1;
                done_d  = 1'b0;
                state_d = S_HDR;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
        if (state_d != state_q) to_cnt_d = '0;
`endif

        iw_ptr_d = iw_ptr_q + (AW+1)'(push_instr);
        ir_ptr_d = ir_ptr_q + (AW+1)'(pop_instr);
        dw_ptr_d = dw_ptr_q + (AW+1)'(push_data);
        dr_ptr_d = dr_ptr_q + (AW+1)'(pop_data);
        if (flush) begin
            iw_ptr_d = '0;
            ir_ptr_d = '0;
            dw_ptr_d = '0;
            dr_ptr_d = '0;
        end

        // Ready is registered, so it looks ahead at next state and next fill level.
        cmd_ready_d = (state_d == S_HDR     && !ptr_full(iw_ptr_d, ir_ptr_d)) ||
                      (state_d == S_PAYLOAD && !ptr_full(dw_ptr_d, dr_ptr_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            op_q        <= 1'b0;
            work_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            iw_ptr_q    <= '0;
            ir_ptr_q    <= '0;
            dw_ptr_q    <= '0;
            dr_ptr_q    <= '0;
`ifdef JTAG_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            iw_ptr_q    <= iw_ptr_d;
            ir_ptr_q    <= ir_ptr_d;
            dw_ptr_q    <= dw_ptr_d;
            dr_ptr_q    <= dr_ptr_d;
`ifdef JTAG_SEQ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // NOTE: storage arrays have no reset; the reset pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_instr) imem[iw_ptr_q[AW-1:0]] <= cmd_data[DATA_INSTRUCTION-1:0];
        if (push_data)  dmem[dw_ptr_q[AW-1:0]] <= cmd_data[DATA_FIFO-1:0];
    end

    assign cmd_ready = cmd_ready_q;
    assign op        = op_q;
    assign work      = work_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
